// File: rtl/control_multiciclo_pkg.sv
// Shared encodings for the multi-cycle MIPS-style control path: opcodes,
// FSM state encoding and the datapath select codes used by the muxes.
package control_multiciclo_pkg;

  // Supported opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // FSM states; IDLE must stay at zero so estado reads 0 in reset
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_EXEC_R    = 4'd3,
    ST_WB_R      = 4'd4,
    ST_EXEC_I    = 4'd5,
    ST_WB_I      = 4'd6,
    ST_MEM_ADDR  = 4'd7,
    ST_MEM_READ  = 4'd8,
    ST_WB_MEM    = 4'd9,
    ST_MEM_WRITE = 4'd10,
    ST_BRANCH    = 4'd11,
    ST_JUMP      = 4'd12
  } state_t;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_supported_op(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction

endpackage

// File: rtl/control_multiciclo.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/write-back sequencing
// for R-type, lw, sw, beq, addi and j, with memory-ready stalls.
module control_multiciclo
  import control_multiciclo_pkg::*;
#(
  parameter int unsigned OPC_W   = 6,
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               regdst,
  output logic               regwrite,
  output logic               alusrc_a,
  output logic [1:0]         alusrc_b,
  output logic [1:0]         aluop,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               memtoreg,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               pcwritecond,
  output logic [1:0]         pcsrc,
  output logic               illegal,
  output logic [STATE_W-1:0] estado
);

  state_t     state_q, state_d;
  logic [5:0] op;
  // The branch decision is taken in the datapath (PC load gated by zero)
  logic       unused_zero;

  assign op          = 6'(opcode);
  assign unused_zero = zero;
  assign estado      = STATE_W'(state_q);

  // State register, asynchronously forced to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state selection; unknown encodings fall back to IDLE
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:      state_d = ST_FETCH;
      ST_FETCH:     state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (op)
          OP_RTYPE:     state_d = ST_EXEC_R;
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_EXEC_I;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_EXEC_R:    state_d = ST_WB_R;
      ST_WB_R:      state_d = ST_FETCH;
      ST_EXEC_I:    state_d = ST_WB_I;
      ST_WB_I:      state_d = ST_FETCH;
      ST_MEM_ADDR:  state_d = (op == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  state_d = mem_ready ? ST_WB_MEM : ST_MEM_READ;
      ST_WB_MEM:    state_d = ST_FETCH;
      ST_MEM_WRITE: state_d = mem_ready ? ST_FETCH : ST_MEM_WRITE;
      ST_BRANCH:    state_d = ST_FETCH;
      ST_JUMP:      state_d = ST_FETCH;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Moore output decode; FETCH loads are qualified by mem_ready, DECODE flags bad opcodes
  always_comb begin
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrc_a    = 1'b0;
    alusrc_b    = SRCB_REG;
    aluop       = ALUOP_ADD;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    memtoreg    = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    pcsrc       = PCSRC_ALU;
    illegal     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        memread  = 1'b1;
        alusrc_b = SRCB_FOUR;
        irwrite  = mem_ready;
        pcwrite  = mem_ready;
      end
      ST_DECODE: begin
        alusrc_b = SRCB_IMM_SH;
        illegal  = ~is_supported_op(op);
      end
      ST_EXEC_R: begin
        alusrc_a = 1'b1;
        aluop    = ALUOP_FUNCT;
      end
      ST_WB_R: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        alusrc_a = 1'b1;
        alusrc_b = SRCB_IMM;
      end
      ST_WB_I: begin
        regwrite = 1'b1;
      end
      ST_MEM_READ: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      ST_WB_MEM: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      ST_MEM_WRITE: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      ST_BRANCH: begin
        alusrc_a    = 1'b1;
        aluop       = ALUOP_SUB;
        pcwritecond = 1'b1;
        pcsrc       = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Bench for control_multiciclo: an instruction-level plan model checked every
// cycle, directed literal sequences, then randomized opcodes/stalls/resets.
module tb_control_multiciclo;
  import control_multiciclo_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       regdst, regwrite, alusrc_a, iord, memread, memwrite, memtoreg;
  logic       irwrite, pcwrite, pcwritecond, illegal;
  logic [1:0] alusrc_b, aluop, pcsrc;
  logic [3:0] estado;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       regdst;
    logic       regwrite;
    logic       alusrc_a;
    logic [1:0] alusrc_b;
    logic [1:0] aluop;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       irwrite;
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] pcsrc;
    logic       illegal;
  } ctl_t;

  ctl_t dut_ctl;
  assign dut_ctl = {regdst, regwrite, alusrc_a, alusrc_b, aluop, iord, memread,
                    memwrite, memtoreg, irwrite, pcwrite, pcwritecond, pcsrc, illegal};

  control_multiciclo #(.OPC_W(6), .STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .regdst(regdst), .regwrite(regwrite), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b),
    .aluop(aluop), .iord(iord), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .irwrite(irwrite), .pcwrite(pcwrite),
    .pcwritecond(pcwritecond), .pcsrc(pcsrc), .illegal(illegal), .estado(estado)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: per-instruction step plan ----------------
  function automatic logic legal_op(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // Control word each step must present, straight from the step descriptions
  function automatic ctl_t expect_ctl(input state_t s, input logic mr, input logic [5:0] op);
    ctl_t c;
    c = '0;
    case (s)
      ST_FETCH:     begin c.memread = 1'b1; c.alusrc_b = 2'b01; c.irwrite = mr; c.pcwrite = mr; end
      ST_DECODE:    begin c.alusrc_b = 2'b11; c.illegal = ~legal_op(op); end
      ST_EXEC_R:    begin c.alusrc_a = 1'b1; c.aluop = 2'b10; end
      ST_WB_R:      begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      ST_EXEC_I:    begin c.alusrc_a = 1'b1; c.alusrc_b = 2'b10; end
      ST_WB_I:      c.regwrite = 1'b1;
      ST_MEM_ADDR:  begin c.alusrc_a = 1'b1; c.alusrc_b = 2'b10; end
      ST_MEM_READ:  begin c.memread = 1'b1; c.iord = 1'b1; end
      ST_WB_MEM:    begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      ST_MEM_WRITE: begin c.memwrite = 1'b1; c.iord = 1'b1; end
      ST_BRANCH:    begin c.alusrc_a = 1'b1; c.aluop = 2'b01; c.pcwritecond = 1'b1; c.pcsrc = 2'b01; end
      ST_JUMP:      begin c.pcwrite = 1'b1; c.pcsrc = 2'b10; end
      default:      c = '0;
    endcase
    return c;
  endfunction

  bit     m_idle = 1'b1;
  state_t plan[$];
  state_t m_cur;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle = 1'b1;
      plan.delete();
    end else if (m_idle) begin
      m_idle = 1'b0;
      plan.push_back(ST_FETCH);
    end else begin
      m_cur = plan[0];
      if (!((m_cur == ST_FETCH || m_cur == ST_MEM_READ || m_cur == ST_MEM_WRITE) && !mem_ready)) begin
        void'(plan.pop_front());
        if (m_cur == ST_FETCH) begin
          plan.push_back(ST_DECODE);
          case (opcode)
            6'b000000: begin plan.push_back(ST_EXEC_R); plan.push_back(ST_WB_R); end
            6'b100011: begin plan.push_back(ST_MEM_ADDR); plan.push_back(ST_MEM_READ); plan.push_back(ST_WB_MEM); end
            6'b101011: begin plan.push_back(ST_MEM_ADDR); plan.push_back(ST_MEM_WRITE); end
            6'b000100: plan.push_back(ST_BRANCH);
            6'b001000: begin plan.push_back(ST_EXEC_I); plan.push_back(ST_WB_I); end
            6'b000010: plan.push_back(ST_JUMP);
            default: ;
          endcase
        end
        if (plan.size() == 0) plan.push_back(ST_FETCH);
      end
    end
  end

  // Every-cycle comparison against the model, plus the exclusion invariants
  always @(negedge clk) begin
    ctl_t       e;
    logic [3:0] es;
    if (rst || m_idle || plan.size() == 0) begin
      e  = '0;
      es = 4'd0;
    end else begin
      e  = expect_ctl(plan[0], mem_ready, opcode);
      es = 4'(plan[0]);
    end
    n_checks++;
    if (dut_ctl !== e || estado !== es) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t: estado act=%0d req=%0d ctl act=%b req=%b",
               $time, estado, es, dut_ctl, e);
    end
    n_checks++;
    if ((regwrite && memwrite) || (pcwrite && pcwritecond) || (memread && memwrite)) begin
      n_fail++;
      $display("FAIL exclusion t=%0t: ctl act=%b required no conflicting enables", $time, dut_ctl);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0t: act=%0h req=%0h", nm, $time, act, req);
    end
  endtask

  task automatic tick(input logic mr, input logic [5:0] op);
    @(posedge clk);
    #1;
    mem_ready = mr;
    opcode    = op;
    @(negedge clk);
  endtask

  // Advance one cycle and pin the state plus the literal signals of that step
  task automatic stepchk(input string nm, input logic mr, input logic [5:0] op, input state_t exp);
    tick(mr, op);
    chk({nm, " state"}, 32'(estado), 32'(exp));
    if (exp != ST_WB_R) chk({nm, " regdst"}, 32'(regdst), 32'd0);
    case (exp)
      ST_FETCH:     begin chk({nm, " memread"}, 32'(memread), 32'd1);
                          chk({nm, " irwrite"}, 32'(irwrite), 32'(mr));
                          chk({nm, " illegal"}, 32'(illegal), 32'd0); end
      ST_DECODE:    chk({nm, " illegal"}, 32'(illegal), (op == 6'b111111) ? 32'd1 : 32'd0);
      ST_WB_R:      begin chk({nm, " regdst"}, 32'(regdst), 32'd1);
                          chk({nm, " regwrite"}, 32'(regwrite), 32'd1); end
      ST_WB_MEM:    chk({nm, " wbmem"}, {29'd0, regdst, memtoreg, regwrite}, 32'b011);
      ST_MEM_WRITE: chk({nm, " memwrite"}, {29'd0, memwrite, iord, regwrite}, 32'b110);
      ST_BRANCH:    chk({nm, " branch"}, {27'd0, pcwritecond, pcsrc, aluop}, 32'b10101);
      ST_JUMP:      chk({nm, " jump"}, {29'd0, pcwrite, pcsrc}, 32'b110);
      default: ;
    endcase
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned r;
    logic [5:0]  ops [6];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    rst = 1'b1; mem_ready = 1'b0; opcode = 6'd0; zero = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ctl", 32'(dut_ctl), 32'd0);
    chk("reset estado", 32'(estado), 32'd0);
    @(posedge clk); #1; rst = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;
    @(negedge clk);
    chk("idle before first edge", 32'(estado), 32'd0);

    // R-type, no waits: 4 cycles
    stepchk("R", 1'b1, 6'b000000, ST_FETCH);
    stepchk("R", 1'b1, 6'b000000, ST_DECODE);
    stepchk("R", 1'b1, 6'b000000, ST_EXEC_R);
    stepchk("R", 1'b1, 6'b000000, ST_WB_R);
    // lw with two wait cycles in MEM_READ: 7 cycles
    stepchk("LW", 1'b1, 6'b100011, ST_FETCH);
    stepchk("LW", 1'b1, 6'b100011, ST_DECODE);
    stepchk("LW", 1'b1, 6'b100011, ST_MEM_ADDR);
    stepchk("LW", 1'b0, 6'b100011, ST_MEM_READ);
    stepchk("LW", 1'b0, 6'b100011, ST_MEM_READ);
    stepchk("LW", 1'b1, 6'b100011, ST_MEM_READ);
    stepchk("LW", 1'b1, 6'b100011, ST_WB_MEM);
    // sw, no waits: 4 cycles
    stepchk("SW", 1'b1, 6'b101011, ST_FETCH);
    stepchk("SW", 1'b1, 6'b101011, ST_DECODE);
    stepchk("SW", 1'b1, 6'b101011, ST_MEM_ADDR);
    stepchk("SW", 1'b1, 6'b101011, ST_MEM_WRITE);
    // beq and j: 3 cycles each
    stepchk("BEQ", 1'b1, 6'b000100, ST_FETCH);
    stepchk("BEQ", 1'b1, 6'b000100, ST_DECODE);
    stepchk("BEQ", 1'b1, 6'b000100, ST_BRANCH);
    stepchk("J", 1'b1, 6'b000010, ST_FETCH);
    stepchk("J", 1'b1, 6'b000010, ST_DECODE);
    stepchk("J", 1'b1, 6'b000010, ST_JUMP);
    // addi: 4 cycles
    stepchk("ADDI", 1'b1, 6'b001000, ST_FETCH);
    stepchk("ADDI", 1'b1, 6'b001000, ST_DECODE);
    stepchk("ADDI", 1'b1, 6'b001000, ST_EXEC_I);
    stepchk("ADDI", 1'b1, 6'b001000, ST_WB_I);
    // illegal opcode: one-cycle pulse in DECODE, then FETCH
    stepchk("ILL", 1'b1, 6'b111111, ST_FETCH);
    stepchk("ILL", 1'b1, 6'b111111, ST_DECODE);
    // sw with a fetch stall, then reset while MEM_WRITE is stalled
    stepchk("SWR", 1'b0, 6'b101011, ST_FETCH);
    stepchk("SWR", 1'b1, 6'b101011, ST_FETCH);
    stepchk("SWR", 1'b1, 6'b101011, ST_DECODE);
    stepchk("SWR", 1'b1, 6'b101011, ST_MEM_ADDR);
    stepchk("SWR", 1'b0, 6'b101011, ST_MEM_WRITE);
    #1 rst = 1'b1;
    #1;
    chk("async rst memwrite", 32'(memwrite), 32'd0);
    chk("async rst estado", 32'(estado), 32'd0);
    @(posedge clk); #1; rst = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    chk("post rst idle", 32'(estado), 32'd0);
    stepchk("RESTART", 1'b1, 6'b000000, ST_FETCH);

    // randomized traffic, checked by the every-cycle model comparison
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 99) == 0) rst = 1'b1;
      mem_ready = ($urandom_range(0, 3) != 0);
      zero      = 1'($urandom);
      if (!m_idle && plan.size() > 0 && plan[0] == ST_FETCH) begin
        r = $urandom_range(0, 7);
        opcode = (r < 6) ? ops[r] : 6'($urandom);
      end
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
